dsi_packet_parser: RTL and testbench
====================================

Name: dsi_packet_parser

Overview:
- Sits directly upstream of RGBExtractor inside mipi_dsi_top.
- Consumes the de-serialised DSI byte stream from the lane receiver and parses packet headers.
- Emits one 24-bit RGB888 pixel per three payload bytes, plus single-cycle hsync/vsync pulses decoded from HSS/VSS short packets.
- Checks the payload checksum and packet length, and flags errors.

Parameters:
- VC, 2'd0: virtual channel accepted. Packets on any other channel are consumed but produce no output.
- MAX_WC, 16'd3840: largest legal word count. A larger WC raises len_err and the packet is skipped.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- byte_in  in  8  received DSI byte
- byte_valid  in  1  byte_in valid this cycle; no backpressure
- sot  in  1  start-of-transmission pulse; aborts any packet in progress
- pixel_data  out  24  {R,G,B} to RGBExtractor
- pixel_valid  out  1  pixel_data valid, one cycle per pixel
- hsync  out  1  one-cycle pulse on HSS (DT 0x21)
- vsync  out  1  one-cycle pulse on VSS (DT 0x01)
- crc_err  out  1  one-cycle pulse on checksum mismatch
- len_err  out  1  one-cycle pulse on bad WC or truncated packet

Behaviour:
- Reset: clear all outputs to 0, set the state to HDR0 and clear the CRC register. Reset asserted mid-packet drops that packet with no error pulse.
- States: HDR0, HDR1, HDR2, HDR3, PAYLOAD, CRC0, CRC1, SKIP. The state advances only on byte_valid=1; byte_valid=0 holds every register.
- HDR0: capture DI. DT = DI[5:0], vc = DI[7:6].
- HDR1: capture WC LSB.
- HDR2: capture WC MSB.
- HDR3: the ECC byte is accepted and ignored.
- Long packet: DT[3:0] ∈ {9,C,D,E}. Every other DT is a short packet.
- Short packet, after HDR3 → HDR0:
  - If vc==VC and DT==0x01, vsync=1 in the next cycle.
  - If vc==VC and DT==0x21, hsync=1 in the next cycle.
  - All other short DTs produce no output.
- Long packet, after HDR3:
  - If WC>MAX_WC: len_err pulse, state → HDR0, no further bytes consumed for this packet.
  - Else if WC==0: state → CRC0.
  - Else: state → PAYLOAD, byte counter loaded with WC, CRC register set to 16'hFFFF.
- PAYLOAD:
  - Every byte updates the CRC and decrements the counter. Counter reaching 0 → CRC0.
  - If vc==VC and DT==0x3E, bytes are packed R, G, B. pixel_valid=1 and pixel_data={R,G,B} in the cycle after the B byte is accepted (latency 1).
  - For any other DT or VC the payload is consumed silently.
- Residue: if WC mod 3 ≠ 0 for DT 0x3E, the leftover 1–2 bytes are discarded and len_err pulses in the cycle after the last payload byte.
- CRC:
  - CRC-16/CCITT, reflected polynomial 0x8408, init 0xFFFF, LSB-first per byte, no final XOR.
  - Received checksum order: CRC0 = low byte, CRC1 = high byte.
  - On a mismatch, crc_err pulses in the cycle after CRC1. Pixels already emitted are not retracted.
  - State → HDR0.
- SKIP: reserved for a sot-less resync. sot moves SKIP → HDR0.
- sot=1:
  - The state is forced so that, if byte_valid is also 1, that byte is taken as DI (HDR0 behaviour).
  - If sot arrives in any state other than HDR0, len_err pulses once and the partial pixel is discarded.
- Simultaneous events: hsync/vsync, pixel_valid and the error pulses are independent registers and may assert together. pixel_data holds its last value when pixel_valid=0.

Decomposition:
- dsi_pkg holds:
  - DT constants: DT_VSS=6'h01, DT_HSS=6'h21, DT_RGB888=6'h3E.
  - The long-DT test function.
  - The state enum.
  - CRC_POLY=16'h8408 and CRC_INIT=16'hFFFF.
- Sub-module dsi_crc16: byte-wise combinational-next/registered CRC with init, en and byte inputs.

Test Plan:
- VSS short packet 01 00 00 xx → vsync=1 for exactly one cycle, 1 cycle after the 4th byte; hsync stays 0. Then HSS 21 00 00 xx → hsync pulse.
- Long RGB888: DI 3E, WC 0x0006, payload FF 00 00 00 FF 00, bench-computed CRC:
  - pixel_valid pulses twice, pixel_data=FF0000 then 00FF00.
  - crc_err=0.
- Same packet with CRC high byte flipped → both pixels still emitted; crc_err=1 one cycle after the last byte.
- WC=0 long packet 3E 00 00 xx FF FF → no pixel, crc_err=0. WC=4 → one pixel plus len_err after the 4th payload byte.
- VC mismatch: DI=0x7E with VC=0 → no pixel, sync or error outputs; the next packet on VC 0 parses correctly.
- byte_valid gaps (pattern 1,0,0,1) through an RGB888 packet → pixel values unchanged.
- sot pulse mid-payload → len_err=1, the next header is parsed from the sot byte.
- Reset asserted mid-payload → all outputs 0 immediately.

Source files
------------

// File: rtl/dsi_packet_parser_pkg.sv
// Shared definitions for the DSI packet parser: data types, FSM states and CRC helpers.
package dsi_pkg;

  localparam logic [5:0]  DT_VSS    = 6'h01;
  localparam logic [5:0]  DT_HSS    = 6'h21;
  localparam logic [5:0]  DT_RGB888 = 6'h3E;

  localparam logic [15:0] CRC_POLY  = 16'h8408;
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    HDR2,
    HDR3,
    PAYLOAD,
    CRC0,
    CRC1,
    SKIP
  } state_t;

  // Long packets are identified by the low nibble of the data type alone.
  function automatic logic is_long_dt(input logic [5:0] dt);
    case (dt[3:0])
      4'h9, 4'hC, 4'hD, 4'hE: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/dsi_packet_parser_if.sv
// Byte-stream input and decoded video/error outputs of the DSI packet parser.
interface dsi_packet_parser_if;

  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        sot;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        hsync;
  logic        vsync;
  logic        crc_err;
  logic        len_err;

  modport master (
    output byte_in, byte_valid, sot,
    input  pixel_data, pixel_valid, hsync, vsync, crc_err, len_err
  );

  modport slave (
    input  byte_in, byte_valid, sot,
    output pixel_data, pixel_valid, hsync, vsync, crc_err, len_err
  );

endinterface

// File: rtl/dsi_packet_parser_crc16.sv
// Byte-wise CRC-16/CCITT (reflected) accumulator; init wins over en.
module dsi_crc16
  import dsi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;
  logic [15:0] w_next;

  assign w_next = crc16_next(r_crc, i_byte);
  assign o_crc  = r_crc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc <= '0;
    end else if (i_init) begin
      r_crc <= CRC_INIT;
    end else if (i_en) begin
      r_crc <= w_next;
    end
  end

endmodule

// File: rtl/dsi_packet_parser.sv
// DSI packet parser: decodes headers, packs RGB888 payload into pixels, emits sync
// pulses and flags checksum/length errors.
module dsi_packet_parser
  import dsi_pkg::*;
#(
  parameter logic [1:0]  VC     = 2'd0,
  parameter logic [15:0] MAX_WC = 16'd3840
)
(
  input  logic               clk,
  input  logic               reset,
  dsi_packet_parser_if.slave bus
);

  state_t      r_state;
  logic [5:0]  r_dt;
  logic [1:0]  r_vc;
  logic [15:0] r_wc;
  logic [15:0] r_count;
  logic [1:0]  r_pix_idx;
  logic [7:0]  r_red;
  logic [7:0]  r_green;
  logic [7:0]  r_crc_lo;
  logic [23:0] r_pixel_data;
  logic        r_pixel_valid;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_crc_err;
  logic        r_len_err;

  logic        w_take;
  logic        w_own;
  logic        w_rgb;
  logic        w_crc_init;
  logic        w_crc_en;
  logic [15:0] w_crc;

  // A byte arriving with sot belongs to the new packet, never the current one.
  assign w_take     = bus.byte_valid & ~bus.sot;
  assign w_own      = (r_vc == VC);
  assign w_rgb      = w_own && (r_dt == DT_RGB888);
  assign w_crc_init = w_take && (r_state == HDR3) && is_long_dt(r_dt);
  assign w_crc_en   = w_take && (r_state == PAYLOAD);

  dsi_crc16 u_crc (
    .clk    (clk),
    .reset  (reset),
    .i_init (w_crc_init),
    .i_en   (w_crc_en),
    .i_byte (bus.byte_in),
    .o_crc  (w_crc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= HDR0;
      r_dt          <= '0;
      r_vc          <= '0;
      r_wc          <= '0;
      r_count       <= '0;
      r_pix_idx     <= '0;
      r_red         <= '0;
      r_green       <= '0;
      r_crc_lo      <= '0;
      r_pixel_data  <= '0;
      r_pixel_valid <= 1'b0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_crc_err     <= 1'b0;
      r_len_err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let the pulse defaults below be overridden
      // later in the same block without ordering hazards between registers.
      r_pixel_valid <= 1'b0;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_crc_err     <= 1'b0;
      r_len_err     <= 1'b0;

      if (bus.sot) begin
        if (r_state != HDR0) r_len_err <= 1'b1;
        r_pix_idx <= '0;
        if (bus.byte_valid) begin
          r_dt    <= bus.byte_in[5:0];
          r_vc    <= bus.byte_in[7:6];
          r_state <= HDR1;
        end else begin
          r_state <= HDR0;
        end
      end else if (bus.byte_valid) begin
        case (r_state)
          HDR0: begin
            r_dt    <= bus.byte_in[5:0];
            r_vc    <= bus.byte_in[7:6];
            r_state <= HDR1;
          end
          HDR1: begin
            r_wc[7:0] <= bus.byte_in;
            r_state   <= HDR2;
          end
          HDR2: begin
            r_wc[15:8] <= bus.byte_in;
            r_state    <= HDR3;
          end
          HDR3: begin
            r_pix_idx <= '0;
            if (!is_long_dt(r_dt)) begin
              r_vsync <= w_own && (r_dt == DT_VSS);
              r_hsync <= w_own && (r_dt == DT_HSS);
              r_state <= HDR0;
            end else if (r_wc > MAX_WC) begin
              r_len_err <= w_own;
              r_state   <= HDR0;
            end else if (r_wc == 16'd0) begin
              r_state <= CRC0;
            end else begin
              r_count <= r_wc;
              r_state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            r_count <= r_count - 16'd1;
            if (w_rgb) begin
              case (r_pix_idx)
                2'd0:    begin r_red   <= bus.byte_in; r_pix_idx <= 2'd1; end
                2'd1:    begin r_green <= bus.byte_in; r_pix_idx <= 2'd2; end
                default: begin
                  r_pixel_data  <= {r_red, r_green, bus.byte_in};
                  r_pixel_valid <= 1'b1;
                  r_pix_idx     <= 2'd0;
                end
              endcase
            end
            if (r_count == 16'd1) begin
              // The last byte of a whole number of pixels is always a B byte.
              r_len_err <= w_rgb && (r_pix_idx != 2'd2);
              r_state   <= CRC0;
            end
          end
          CRC0: begin
            r_crc_lo <= bus.byte_in;
            r_state  <= CRC1;
          end
          CRC1: begin
            r_crc_err <= w_own && ({bus.byte_in, r_crc_lo} != w_crc);
            r_state   <= HDR0;
          end
          SKIP: r_state <= SKIP;
        endcase
      end
    end
  end

  assign bus.pixel_data  = r_pixel_data;
  assign bus.pixel_valid = r_pixel_valid;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.crc_err     = r_crc_err;
  assign bus.len_err     = r_len_err;

endmodule

// File: tb/tb_dsi_packet_parser.sv
// Self-checking bench: packets are built at byte-list level, a packet-level model
// derives the output events per byte, and one compare process checks every cycle.
module tb_dsi_packet_parser;

  typedef struct packed {
    logic        pv;
    logic [23:0] pd;
    logic        hs;
    logic        vs;
    logic        ce;
    logic        le;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsi_packet_parser_if bus ();

  dsi_packet_parser #(.VC(2'd0), .MAX_WC(16'd3840)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_next;
  exp_t        ev_a [0:4095];
  logic [7:0]  pkt_q [$];
  logic [7:0]  pay_q [$];
  bit          in_pkt = 1'b0;
  logic [23:0] last_pd;
  logic [5:0]  short_dts [0:4] = '{6'h02, 6'h03, 6'h08, 6'h11, 6'h31};
  logic [5:0]  long_dts  [0:2] = '{6'h29, 6'h19, 6'h2C};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // CRC-16/CCITT reflected, init FFFF, no final XOR, over pay_q.
  function automatic logic [15:0] crc_of_pay();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (pay_q[i]) begin
      c = c ^ {8'h00, pay_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  // Expected outputs in the cycle after each byte of pkt_q is accepted.
  function automatic void build_events();
    logic [7:0]  di;
    logic [5:0]  dt;
    bit          own;
    bit          lng;
    int          wc;
    logic [15:0] c;
    logic [15:0] got;
    di  = pkt_q[0];
    dt  = di[5:0];
    own = (di[7:6] == 2'd0);
    wc  = {16'd0, pkt_q[2], pkt_q[1]};
    lng = (dt[3:0] == 4'h9) || (dt[3:0] == 4'hC) || (dt[3:0] == 4'hD) || (dt[3:0] == 4'hE);
    for (int i = 0; i < pkt_q.size(); i++) ev_a[i] = '0;
    if (!lng) begin
      if (own && dt == 6'h01) ev_a[3].vs = 1'b1;
      if (own && dt == 6'h21) ev_a[3].hs = 1'b1;
    end else if (wc > 3840) begin
      if (own) ev_a[3].le = 1'b1;
    end else begin
      pay_q.delete();
      for (int k = 0; k < wc; k++) pay_q.push_back(pkt_q[4 + k]);
      if (own && dt == 6'h3E) begin
        for (int m = 0; m < wc / 3; m++) begin
          ev_a[4 + 3*m + 2].pv = 1'b1;
          ev_a[4 + 3*m + 2].pd = {pkt_q[4 + 3*m], pkt_q[5 + 3*m], pkt_q[6 + 3*m]};
        end
        if (wc % 3 != 0) ev_a[3 + wc].le = 1'b1;
      end
      c   = crc_of_pay();
      got = {pkt_q[5 + wc], pkt_q[4 + wc]};
      if (own && got != c) ev_a[5 + wc].ce = 1'b1;
    end
  endfunction

  task automatic mk_short(input logic [7:0] di);
    pkt_q.delete();
    pkt_q.push_back(di);
    pkt_q.push_back(8'($urandom));
    pkt_q.push_back(8'($urandom));
    pkt_q.push_back(8'($urandom));
  endtask

  task automatic mk_long(input logic [7:0] di, input bit bad_crc);
    logic [15:0] wc;
    logic [15:0] c;
    wc = 16'(pay_q.size());
    c  = crc_of_pay();
    if (bad_crc) c = c ^ 16'hFF00;
    pkt_q.delete();
    pkt_q.push_back(di);
    pkt_q.push_back(wc[7:0]);
    pkt_q.push_back(wc[15:8]);
    pkt_q.push_back(8'($urandom));
    foreach (pay_q[i]) pkt_q.push_back(pay_q[i]);
    pkt_q.push_back(c[7:0]);
    pkt_q.push_back(c[15:8]);
  endtask

  task automatic fill_pay(input int n);
    pay_q.delete();
    repeat (n) pay_q.push_back(8'($urandom));
  endtask

  task automatic drive_cycle(input bit v, input logic [7:0] d, input bit s, input exp_t e);
    @(negedge clk);
    bus.byte_valid = v;
    bus.byte_in    = d;
    bus.sot        = s;
    exp_next       = e;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b0, 8'($urandom), 1'b0, '0);
  endtask

  // gap_mode: 0 back-to-back, 1 two idle cycles between bytes, 2 random 0-2 idles.
  task automatic send_pkt(input int n_send, input int gap_mode, input bit use_sot);
    exp_t e;
    build_events();
    for (int i = 0; i < n_send; i++) begin
      if (i > 0) begin
        if (gap_mode == 1) idle(2);
        else if (gap_mode == 2) idle(int'($urandom_range(0, 2)));
      end
      e = ev_a[i];
      if (i == 0 && use_sot && in_pkt) e.le = 1'b1;
      drive_cycle(1'b1, pkt_q[i], (i == 0) && use_sot, e);
    end
    in_pkt = (n_send < pkt_q.size());
  endtask

  task automatic sot_alone();
    exp_t e;
    e    = '0;
    e.le = in_pkt;
    drive_cycle(1'b0, 8'($urandom), 1'b1, e);
    in_pkt = 1'b0;
  endtask

  // Single compare process: every cycle, outputs against the model's expectation.
  initial begin
    last_pd = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        last_pd = '0;
        check("rst_pixel_valid", 32'(bus.pixel_valid), 32'd0);
        check("rst_pixel_data",  32'(bus.pixel_data),  32'd0);
        check("rst_hsync",       32'(bus.hsync),       32'd0);
        check("rst_vsync",       32'(bus.vsync),       32'd0);
        check("rst_crc_err",     32'(bus.crc_err),     32'd0);
        check("rst_len_err",     32'(bus.len_err),     32'd0);
      end else begin
        if (exp_next.pv) last_pd = exp_next.pd;
        check("pixel_valid", 32'(bus.pixel_valid), 32'(exp_next.pv));
        check("pixel_data",  32'(bus.pixel_data),  32'(last_pd));
        check("hsync",       32'(bus.hsync),       32'(exp_next.hs));
        check("vsync",       32'(bus.vsync),       32'(exp_next.vs));
        check("crc_err",     32'(bus.crc_err),     32'(exp_next.ce));
        check("len_err",     32'(bus.len_err),     32'(exp_next.le));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    bus.sot        = 1'b0;
    exp_next       = '0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Model pins: standard check value and hand-derived event positions.
    pay_q.delete();
    for (int i = 0; i < 9; i++) pay_q.push_back(8'(8'h31 + i));
    check("model_crc_123456789", 32'(crc_of_pay()), 32'h6F91);

    // VSS then HSS short packets.
    mk_short(8'h01);
    send_pkt(4, 0, 1'b0);
    check("model_vss_pos", 32'(ev_a[3].vs), 32'd1);
    idle(2);
    mk_short(8'h21);
    send_pkt(4, 0, 1'b0);
    check("model_hss_pos", 32'(ev_a[3].hs), 32'd1);
    idle(2);

    // RGB888 WC=6, good CRC, then high CRC byte corrupted.
    pay_q = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
    mk_long(8'h3E, 1'b0);
    send_pkt(pkt_q.size(), 0, 1'b0);
    check("model_px0", 32'(ev_a[6].pd), 32'hFF0000);
    check("model_px1", 32'(ev_a[9].pd), 32'h00FF00);
    check("model_crc_ok", 32'(ev_a[11].ce), 32'd0);
    idle(1);
    pay_q = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
    mk_long(8'h3E, 1'b1);
    send_pkt(pkt_q.size(), 0, 1'b0);
    check("model_crc_bad", 32'(ev_a[11].ce), 32'd1);
    idle(1);

    // WC=0 (checksum FF FF) and WC=4 (one pixel plus residue).
    pay_q.delete();
    mk_long(8'h3E, 1'b0);
    check("model_wc0_crc_lo", 32'(pkt_q[4]), 32'hFF);
    send_pkt(pkt_q.size(), 0, 1'b0);
    pay_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    mk_long(8'h3E, 1'b0);
    send_pkt(pkt_q.size(), 0, 1'b0);
    check("model_wc4_residue", 32'(ev_a[7].le), 32'd1);
    idle(1);

    // Foreign virtual channel, then a packet on the accepted one.
    fill_pay(6);
    mk_long(8'h7E, 1'b0);
    send_pkt(pkt_q.size(), 0, 1'b0);
    fill_pay(6);
    mk_long(8'h3E, 1'b0);
    send_pkt(pkt_q.size(), 0, 1'b0);

    // byte_valid gaps through a packet.
    fill_pay(9);
    mk_long(8'h3E, 1'b0);
    send_pkt(pkt_q.size(), 1, 1'b0);
    idle(1);

    // sot mid-payload, new header taken from the sot byte.
    fill_pay(9);
    mk_long(8'h3E, 1'b0);
    send_pkt(8, 0, 1'b0);
    mk_short(8'h01);
    send_pkt(4, 0, 1'b1);
    fill_pay(6);
    mk_long(8'h3E, 1'b0);
    send_pkt(5, 0, 1'b0);
    sot_alone();
    sot_alone();
    idle(1);

    // WC just above and exactly at the limit.
    pkt_q = '{8'h3E, 8'h01, 8'h0F, 8'hA5};
    send_pkt(4, 0, 1'b0);
    mk_short(8'h21);
    send_pkt(4, 0, 1'b0);
    fill_pay(3840);
    mk_long(8'h3E, 1'b0);
    send_pkt(pkt_q.size(), 0, 1'b0);
    idle(1);

    // Reset while a pixel is on the outputs.
    pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    mk_long(8'h3E, 1'b0);
    send_pkt(7, 0, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0, '0);
    #1;
    check("pre_reset_pixel", 32'(bus.pixel_data), 32'h112233);
    rst = 1'b1;
    #1;
    check("async_rst_pixel_data",  32'(bus.pixel_data),  32'd0);
    check("async_rst_pixel_valid", 32'(bus.pixel_valid), 32'd0);
    check("async_rst_len_err",     32'(bus.len_err),     32'd0);
    idle(1);
    rst    = 1'b0;
    in_pkt = 1'b0;
    mk_short(8'h01);
    send_pkt(4, 0, 1'b0);

    // Randomised packet mix.
    for (int p = 0; p < 60; p++) begin
      int         ty;
      int         n;
      logic [1:0] vc;
      logic [15:0] wc;
      bit         bad;
      ty  = int'($urandom_range(0, 5));
      vc  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      bad = (vc == 2'd0) && ($urandom_range(0, 4) == 0);
      case (ty)
        0: mk_short({vc, 6'h01});
        1: mk_short({vc, 6'h21});
        2: mk_short({vc, short_dts[$urandom_range(0, 4)]});
        3: begin fill_pay(int'($urandom_range(0, 20))); mk_long({vc, 6'h3E}, bad); end
        4: begin fill_pay(int'($urandom_range(0, 10))); mk_long({vc, long_dts[$urandom_range(0, 2)]}, bad); end
        default: begin
          wc = 16'($urandom_range(3841, 65535));
          pkt_q.delete();
          pkt_q.push_back(8'h3E);
          pkt_q.push_back(wc[7:0]);
          pkt_q.push_back(wc[15:8]);
          pkt_q.push_back(8'($urandom));
        end
      endcase
      n = pkt_q.size();
      if ($urandom_range(0, 6) == 0) n = int'($urandom_range(1, n - 1));
      send_pkt(n, 2 * int'($urandom_range(0, 1)), in_pkt ? 1'b1 : ($urandom_range(0, 9) == 0));
      idle(int'($urandom_range(0, 2)));
    end
    if (in_pkt) sot_alone();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
